// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
//
// Frame-level controller between a UART receiver/transmitter pair and an ALU.
// It collects three received bytes in order (operand A, operand B, opcode),
// presents them to the ALU, captures the combinational result, and hands that
// result to the transmitter as one byte. An inter-byte watchdog, advanced by
// the baud oversampling tick, discards frames that stall mid-way.
//
// Parameters:
//   NB_DATA        width of operands, result and UART bytes
//   NB_OP          opcode width (low NB_OP bits of the opcode byte)
//   TIMEOUT_TICKS  oversampling ticks allowed between bytes of one frame
//
// Ports:
//   i_clock       system clock
//   i_reset       asynchronous, active-low reset
//   i_tick        one-cycle baud oversampling tick
//   i_rx_done     one-cycle pulse, i_rx_data holds a new byte
//   i_rx_data     received byte
//   i_tx_done     one-cycle pulse, transmitter finished a byte
//   i_alu_result  combinational ALU result
//   o_alu_a       registered operand A
//   o_alu_b       registered operand B
//   o_alu_op      registered opcode
//   o_tx_start    one-cycle transmit request
//   o_tx_data     byte to transmit, held until the next frame's result
//   o_busy        high in every state except IDLE
//   o_error       one-cycle pulse on invalid opcode, timeout or overrun
// -----------------------------------------------------------------------------
module uart_alu_sequencer #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error
);

  localparam int                NB_CNT  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_TICKS);

  // Supported ALU opcodes
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t             r_state;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_error;
  logic               r_busy;
  logic [NB_CNT-1:0]  r_wd_cnt;

  logic [NB_OP-1:0]   w_op;
  logic               w_op_valid;
  logic               w_timeout;

  // Upper bits of the opcode byte are don't-care
  assign w_op = i_rx_data[NB_OP-1:0];

  always_comb begin
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: w_op_valid = 1'b1;
      default:                        w_op_valid = 1'b0;
    endcase
  end

  // Only consulted in WAIT_B / WAIT_OP, where the watchdog is armed
  assign w_timeout = (r_wd_cnt == CNT_MAX);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_wd_cnt   <= '0;
    end else begin
      // Pulse outputs default low; each event raises them for one cycle
      r_tx_start <= 1'b0;
      r_error    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_wd_cnt <= '0;
          if (i_rx_done) begin
            r_alu_a <= i_rx_data;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT_B;
          end
        end

        ST_WAIT_B: begin
          // A byte arriving in the timeout cycle wins over the timeout
          if (i_rx_done) begin
            r_alu_b  <= i_rx_data;
            r_wd_cnt <= '0;
            r_state  <= ST_WAIT_OP;
          end else if (w_timeout) begin
            r_error  <= 1'b1;
            r_wd_cnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (i_tick) begin
            // Saturation is implicit: at CNT_MAX the timeout branch is taken
            r_wd_cnt <= r_wd_cnt + NB_CNT'(1);
          end
        end

        ST_WAIT_OP: begin
          if (i_rx_done) begin
            r_wd_cnt <= '0;
            if (w_op_valid) begin
              r_alu_op <= w_op;
              r_state  <= ST_EXEC;
            end else begin
              // Bad opcode: abandon the frame, keep the previous opcode
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_error  <= 1'b1;
            r_wd_cnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (i_tick) begin
            r_wd_cnt <= r_wd_cnt + NB_CNT'(1);
          end
        end

        ST_EXEC: begin
          // ALU inputs have been stable for a full cycle here
          r_tx_data  <= i_alu_result;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
          if (i_rx_done) begin
            r_error <= 1'b1;
          end
        end

        ST_SEND: begin
          // o_tx_start is high during this state
          r_state <= ST_WAIT_TX;
          if (i_rx_done) begin
            r_error <= 1'b1;
          end
        end

        ST_WAIT_TX: begin
          if (i_rx_done) begin
            r_error <= 1'b1;
          end
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_error    = r_error;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_sequencer
//
// Scoreboard bench: the stimulus process pushes every expected DUT event
// (transmit request with result, or error pulse) together with the cycle it
// must appear in; an independent monitor pops and compares whenever the DUT
// raises o_tx_start or o_error. The bench also plays the ALU and the UART
// transmitter.
// -----------------------------------------------------------------------------
module tb_uart_alu_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 640;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tick;
  logic               rx_done;
  logic [NB_DATA-1:0] rx_data;
  logic               tx_done;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_error;

  always #5 clk = ~clk;

  uart_alu_sequencer #(
    .NB_DATA       (NB_DATA),
    .NB_OP         (NB_OP),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_tick       (tick),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_tx;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] last_op;
  int         tick_mode = 0;
  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  // Reference ALU semantics
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return $signed(a) >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_ok(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // The bench acts as the combinational ALU
  always_comb alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic handle(input bit is_tx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s actual=1 required=0 (cycle %0d)",
               is_tx ? "tx_start" : "error", cyc);
    end else begin
      e = sb.pop_front();
      chk("event_is_tx", 32'(is_tx), 32'(e.is_tx));
      chk("event_cycle", cyc, e.cyc);
      if (is_tx && e.is_tx) begin
        chk("tx_data", 32'(o_tx_data), 32'(e.res));
        chk("alu_a", 32'(o_alu_a), 32'(e.a));
        chk("alu_b", 32'(o_alu_b), 32'(e.b));
        chk("alu_op", 32'(o_alu_op), 32'(e.op));
        $display("tx   cyc=%0d a=%02h b=%02h op=%02h data=%02h", cyc, o_alu_a, o_alu_b,
                 o_alu_op, o_tx_data);
      end else begin
        $display("err  cyc=%0d", cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_error) handle(1'b0);
      if (o_tx_start) handle(1'b1);
    end
  end

  // ---------------- tick generator ----------------
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tick_mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- transmitter model ----------------
  // Finishes a byte 3..6 cycles after the request; also emits stray
  // tx_done pulses while idle, which the DUT must ignore.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1) begin
        repeat ($urandom_range(3, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end else if (rst_n === 1'b1 && o_busy === 1'b0 && $urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Byte is sampled at the edge after acyc; registered effects appear at acyc+1.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acyc);
    repeat (gap + 1) @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    acyc    = cyc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (o_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout actual=busy required=idle within %0d cycles", name, bound);
    end
  endtask

  task automatic push_err(input int c);
    exp_t e;
    e.is_tx = 1'b0;
    e.cyc   = c;
    e.a     = '0;
    e.b     = '0;
    e.op    = '0;
    e.res   = '0;
    sb.push_back(e);
  endtask

  // Full frame; gap_b is the idle cycles before operand B
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int gap_b, input bit overrun);
    int   t;
    int   t2;
    exp_t e;
    logic [7:0] res;
    send_byte(a, $urandom_range(0, 4), t);
    send_byte(b, gap_b, t);
    send_byte(opb, $urandom_range(0, 4), t);
    if (op_ok(opb[5:0])) begin
      res     = alu_fn(a, b, opb[5:0]);
      e.is_tx = 1'b1;
      e.cyc   = t + 2;
      e.a     = a;
      e.b     = b;
      e.op    = opb[5:0];
      e.res   = res;
      sb.push_back(e);
      last_op = opb[5:0];
      if (overrun) begin
        send_byte(8'($urandom), 1, t2);
        push_err(t2 + 1);
      end
      wait_idle("frame", 100);
      chk("tx_data_hold", 32'(o_tx_data), 32'(res));
    end else begin
      push_err(t + 1);
      wait_idle("bad_op", 100);
      chk("op_kept", 32'(o_alu_op), 32'(last_op));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_alu_a"}, 32'(o_alu_a), 32'h0);
    chk({tag, "_alu_b"}, 32'(o_alu_b), 32'h0);
    chk({tag, "_alu_op"}, 32'(o_alu_op), 32'h0);
    chk({tag, "_tx_data"}, 32'(o_tx_data), 32'h0);
    chk({tag, "_tx_start"}, 32'(o_tx_start), 32'h0);
    chk({tag, "_error"}, 32'(o_error), 32'h0);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [7:0] opb;
    rst_n   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    last_op = 6'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed frames
    send_frame(8'h05, 8'h03, 8'h20, 0, 1'b0);
    send_frame(8'h02, 8'h05, 8'h22, 0, 1'b0);
    send_frame(8'h80, 8'h01, 8'h03, 0, 1'b0);
    send_frame(8'h12, 8'h34, 8'h3F, 0, 1'b0);   // invalid opcode
    send_frame(8'hF0, 8'h0F, 8'hE5, 0, 1'b1);   // OR with ignored upper bits, overrun

    // Watchdog: tick every cycle so the timeout cycle is exact
    tick_mode = 1;
    send_byte(8'hAA, 0, t);
    chk("busy_after_a", 32'(o_busy), 32'h1);
    push_err(t + 1 + TO + 1);
    wait_idle("timeout", TO + 50);
    send_frame(8'h01, 8'h01, 8'h24, 0, 1'b0);
    // Operand B lands in the very cycle the counter reaches its limit
    send_frame(8'h33, 8'h0F, 8'h26, TO - 1, 1'b0);
    tick_mode = 0;

    // Reset asserted in WAIT_OP
    send_byte(8'h77, 0, t);
    send_byte(8'h66, 0, t);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    last_op = 6'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h05, 8'h03, 8'h20, 0, 1'b0);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) != 0)
        opb = {2'($urandom_range(0, 3)), valid_ops[$urandom_range(0, 7)]};
      else
        opb = 8'($urandom);
      send_frame(8'($urandom), 8'($urandom), opb, $urandom_range(0, 8),
                 $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_events actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
